// File: rtl/cpu_decode_queue.sv
// cpu_decode_queue: decode buffer between fetch and issue.
// Up to IN_W fetched instructions are decoded as they enter, optionally
// stripped of zero-destination NOPs, and held in a DEPTH-entry circular
// queue. The head record is presented to issue over valid/ready.
// The head comes straight from queue storage, so no in_* signal reaches
// any out_* signal combinationally.
module cpu_decode_queue #(
  parameter int DEPTH    = 8,
  parameter int IN_W     = 2,
  parameter int SKIP_NOP = 1,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [IN_W-1:0]            in_valid,
  input  logic [32*IN_W-1:0]         in_inst,
  input  logic [32*IN_W-1:0]         in_pc,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_inst,
  output logic [31:0]                out_pc,
  output logic [4:0]                 out_rr1,
  output logic [4:0]                 out_rr2,
  output logic [4:0]                 out_rw,
  output logic [7:0]                 out_flags,
  output logic                       out_could_branch,
  output logic                       out_nop,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_W-1:0]           nop_dropped
);

  localparam int   PTR_W = $clog2(DEPTH);
  localparam int   OCC_W = PTR_W + 1;
  localparam logic SKIP  = (SKIP_NOP != 0);

  // One decoded queue entry.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [4:0]  rw;
    logic [7:0]  flags;   // {exc, cp0, branch, mul, shift, alu, store, load}
    logic        could_branch;
    logic        nop;
  } dq_rec_t;

  // Pure decode of one instruction word into a queue record.
  function automatic dq_rec_t decode(input logic [31:0] inst, input logic [31:0] pc);
    dq_rec_t     rec;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  fn;
    logic        is_r;
    logic        load;
    logic        store;
    logic        alu_r;
    logic        alu_i;
    logic        shift;
    logic        mul;
    logic        jr;
    logic        jabs;
    logic        bcmp;
    logic        bequ;
    logic        branch;
    logic        cp0;
    logic        exc;
    logic        cb;
    logic        link;
    op     = inst[31:26];
    rs     = inst[25:21];
    rt     = inst[20:16];
    rd     = inst[15:11];
    fn     = inst[5:0];
    is_r   = (op == 6'b000000);
    load   = (op[5:3] == 3'b100);
    store  = (op[5:3] == 3'b101);
    alu_r  = is_r & (fn[5:4] == 2'b10);
    alu_i  = (op[5:3] == 3'b001);
    shift  = is_r & (fn[5:3] == 3'b000);
    mul    = is_r & (fn[5:4] == 2'b01);
    jr     = is_r & (fn[5:1] == 5'b00100);
    jabs   = (op[5:1] == 5'b00001);
    bcmp   = (op == 6'b000001);
    bequ   = (op[5:2] == 4'b0001);
    branch = jr | jabs | bcmp | bequ;
    cp0    = (op == 6'b010000);
    exc    = is_r & (fn[5:1] == 5'b00110);
    // Trapping add/sub/addi can raise overflow, so they count as redirects.
    cb     = load | store | branch | exc | cp0
           | (alu_r & ((fn == 6'b100000) | (fn == 6'b100010)))
           | (op == 6'b001000);
    // Link forms: jal, and bltzal/bgezal.
    link   = (op == 6'b000011) | (bcmp & ((rt == 5'b10000) | (rt == 5'b10001)));

    rec.inst         = inst;
    rec.pc           = pc;
    rec.rr1          = (jabs | exc) ? 5'd0 : rs;
    rec.rr2          = (load | store | alu_i | bcmp | bequ | jabs) ? 5'd0 : rt;
    if ((op == 6'b000010) | store)
      rec.rw = 5'd0;
    else if (link)
      rec.rw = 5'd31;
    else if (branch)
      rec.rw = 5'd0;
    else if (load | alu_i)
      rec.rw = rt;
    else
      rec.rw = rd;
    rec.flags        = {exc, cp0, branch, mul, shift, alu_r | alu_i, store, load};
    rec.could_branch = cb;
    rec.nop          = ~cb & ((((alu_r | shift) & (rd == 5'd0))) | (alu_i & (rt == 5'd0)));
    return rec;
  endfunction

  dq_rec_t             mem [DEPTH];
  dq_rec_t             dec [IN_W];
  logic [IN_W-1:0]     keep;
  logic [IN_W-1:0]     drop;
  logic [PTR_W-1:0]    waddr [IN_W];
  logic [OCC_W-1:0]    accept_cnt;
  logic [OCC_W-1:0]    drop_cnt;

  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [OCC_W-1:0]    occupancy_reg;
  logic [OCC_W-1:0]    occupancy_next;
  logic [CNT_W-1:0]    nop_dropped_reg;
  logic [CNT_W:0]      drop_sum;

  logic                enq_fire;
  logic                deq_fire;
  dq_rec_t             head;

  // Per-slot decoders and keep/drop classification.
  generate
    for (genvar gi = 0; gi < IN_W; gi++) begin : g_slot
      assign dec[gi]  = decode(in_inst[32*gi +: 32], in_pc[32*gi +: 32]);
      assign keep[gi] = in_valid[gi] & ~(SKIP & dec[gi].nop);
      assign drop[gi] = in_valid[gi] &  (SKIP & dec[gi].nop);
    end
  endgenerate

  // Compact kept slots: each kept slot lands after the earlier kept ones.
  always_comb begin
    logic [OCC_W-1:0] run;
    run      = '0;
    drop_cnt = '0;
    for (int i = 0; i < IN_W; i++) begin
      waddr[i] = wr_ptr_reg + run[PTR_W-1:0];
      run      = run + OCC_W'(keep[i]);
      drop_cnt = drop_cnt + OCC_W'(drop[i]);
    end
    accept_cnt = run;
  end

  // Handshakes; flush cancels both sides for this cycle.
  assign in_ready  = ((OCC_W'(DEPTH) - occupancy_reg) >= OCC_W'(IN_W));
  assign out_valid = (occupancy_reg != '0);
  assign enq_fire  = in_ready & (|in_valid) & ~flush;
  assign deq_fire  = out_valid & out_ready & ~flush;

  // Next occupancy and saturating drop sum.
  always_comb begin
    occupancy_next = occupancy_reg;
    if (flush)
      occupancy_next = '0;
    else
      occupancy_next = occupancy_reg + (enq_fire ? accept_cnt : '0) - OCC_W'(deq_fire);
    drop_sum = {1'b0, nop_dropped_reg} + (CNT_W+1)'(drop_cnt);
  end

  // Queue storage: kept slots written at consecutive wrapped addresses.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_W; i++) begin
      if (enq_fire && keep[i])
        mem[waddr[i]] <= dec[i];
    end
  end

  // Pointers, occupancy and the dropped-NOP counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      occupancy_reg   <= '0;
      nop_dropped_reg <= '0;
    end else begin
      occupancy_reg <= occupancy_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (enq_fire)
          wr_ptr_reg <= wr_ptr_reg + accept_cnt[PTR_W-1:0];
        if (deq_fire)
          rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (enq_fire)
        nop_dropped_reg <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end
  end

  // Head record drives issue directly from storage.
  assign head             = mem[rd_ptr_reg];
  assign out_inst         = head.inst;
  assign out_pc           = head.pc;
  assign out_rr1          = head.rr1;
  assign out_rr2          = head.rr2;
  assign out_rw           = head.rw;
  assign out_flags        = head.flags;
  assign out_could_branch = head.could_branch;
  assign out_nop          = head.nop;
  assign occupancy        = occupancy_reg;
  assign nop_dropped      = nop_dropped_reg;

endmodule

// File: tb/tb_cpu_decode_queue.sv
// tb_cpu_decode_queue: directed test-plan cases plus randomized traffic,
// checked against a queue-based reference model of the decode buffer.
module tb_cpu_decode_queue;

  localparam int DEPTH = 8;
  localparam int IN_W  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  in_valid = '0;
  logic [63:0] in_inst = '0;
  logic [63:0] in_pc = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [4:0]  out_rr1;
  logic [4:0]  out_rr2;
  logic [4:0]  out_rw;
  logic [7:0]  out_flags;
  logic        out_could_branch;
  logic        out_nop;
  logic [3:0]  occupancy;
  logic [15:0] nop_dropped;

  cpu_decode_queue #(.DEPTH(DEPTH), .IN_W(IN_W), .SKIP_NOP(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_rr1(out_rr1), .out_rr2(out_rr2),
    .out_rw(out_rw), .out_flags(out_flags), .out_could_branch(out_could_branch),
    .out_nop(out_nop), .occupancy(occupancy), .nop_dropped(nop_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    int          rr1;
    int          rr2;
    int          rw;
    int          flags;
    bit          cb;
    bit          nop;
  } m_rec_t;

  m_rec_t      m_q[$];
  int          m_drop = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] pc_base = 32'h0040_0000;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference decode, written as opcode/function range tests.
  function automatic m_rec_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
    m_rec_t m;
    int op, rs, rt, rd, fn;
    bit load, store, alu_r, alu_i, shift, mul, jr, jabs, bcmp, bequ, branch, cp0, exc;
    op = int'(inst[31:26]); rs = int'(inst[25:21]); rt = int'(inst[20:16]);
    rd = int'(inst[15:11]); fn = int'(inst[5:0]);
    load   = (op >= 32 && op <= 39);
    store  = (op >= 40 && op <= 47);
    alu_i  = (op >= 8 && op <= 15);
    alu_r  = (op == 0 && fn >= 32 && fn <= 47);
    shift  = (op == 0 && fn <= 7);
    mul    = (op == 0 && fn >= 16 && fn <= 31);
    jr     = (op == 0 && (fn == 8 || fn == 9));
    jabs   = (op == 2 || op == 3);
    bcmp   = (op == 1);
    bequ   = (op >= 4 && op <= 7);
    branch = jr || jabs || bcmp || bequ;
    cp0    = (op == 16);
    exc    = (op == 0 && (fn == 12 || fn == 13));
    m.inst = inst;
    m.pc   = pc;
    m.cb   = load || store || branch || exc || cp0 || (alu_r && (fn == 32 || fn == 34)) || op == 8;
    m.nop  = !m.cb && (((alu_r || shift) && rd == 0) || (alu_i && rt == 0));
    m.rr1  = (jabs || exc) ? 0 : rs;
    m.rr2  = (load || store || alu_i || bcmp || bequ || jabs) ? 0 : rt;
    if (op == 2 || store)                          m.rw = 0;
    else if (op == 3 || (bcmp && (rt == 16 || rt == 17))) m.rw = 31;
    else if (branch)                               m.rw = 0;
    else if (load || alu_i)                        m.rw = rt;
    else                                           m.rw = rd;
    m.flags = (int'(exc) << 7) + (int'(cp0) << 6) + (int'(branch) << 5) + (int'(mul) << 4)
            + (int'(shift) << 3) + (int'(alu_r || alu_i) << 2) + (int'(store) << 1) + int'(load);
    return m;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    logic [4:0]  bt;
    r = $urandom();
    case (r[3:0] % 10)
      0: return 32'h0;
      1: return $urandom();
      2: return {6'd0, r[25:16], 5'd0, r[10:0]};
      3: return {3'b001, r[28:26], r[25:21], 5'd0, r[15:0]};
      4: begin
        case (r[31:30])
          2'd0: bt = 5'd0;
          2'd1: bt = 5'd1;
          2'd2: bt = 5'd16;
          default: bt = 5'd17;
        endcase
        return {6'b000001, r[25:21], bt, r[15:0]};
      end
      5: return {5'b00001, r[26:0]};
      6: return {2'b10, r[29:0]};
      7: return {6'b010000, r[25:0]};
      8: return {6'd0, r[25:11], 5'd0, 4'b1000, r[29], 1'b0};
      default: return {6'd0, r[25:0]};
    endcase
  endfunction

  // Drive one cycle of inputs, compare against the model, then advance it.
  task automatic step(input logic r, input logic fl, input logic [1:0] v,
                      input logic [31:0] i0, input logic [31:0] i1, input logic ordy);
    m_rec_t m;
    logic [31:0] insts [2];
    logic [31:0] pcs [2];
    bit can_enq;
    bit deq;
    @(negedge clk);
    rst = r; flush = fl; in_valid = v; out_ready = ordy;
    insts[0] = i0; insts[1] = i1;
    pcs[0] = pc_base; pcs[1] = pc_base + 32'd4;
    pc_base = pc_base + 32'd8;
    in_inst = {i1, i0};
    in_pc = {pcs[1], pcs[0]};
    #1;
    check_eq("in_ready", 64'(in_ready), 64'((DEPTH - m_q.size()) >= IN_W));
    check_eq("occupancy", 64'(occupancy), 64'(m_q.size()));
    check_eq("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
    check_eq("nop_dropped", 64'(nop_dropped), 64'(m_drop));
    if (m_q.size() != 0) begin
      check_eq("out_inst", 64'(out_inst), 64'(m_q[0].inst));
      check_eq("out_pc", 64'(out_pc), 64'(m_q[0].pc));
      check_eq("out_rr1", 64'(out_rr1), 64'(m_q[0].rr1));
      check_eq("out_rr2", 64'(out_rr2), 64'(m_q[0].rr2));
      check_eq("out_rw", 64'(out_rw), 64'(m_q[0].rw));
      check_eq("out_flags", 64'(out_flags), 64'(m_q[0].flags));
      check_eq("out_could_branch", 64'(out_could_branch), 64'(m_q[0].cb));
      check_eq("out_nop", 64'(out_nop), 64'(m_q[0].nop));
    end
    if (r) begin
      m_q.delete();
      m_drop = 0;
      $display("reset");
    end else if (fl) begin
      m_q.delete();
      $display("flush");
    end else begin
      can_enq = (DEPTH - m_q.size()) >= IN_W;
      deq = (m_q.size() != 0) && ordy;
      if (deq) begin
        $display("deq pc=%08h inst=%08h", m_q[0].pc, m_q[0].inst);
        void'(m_q.pop_front());
      end
      if (can_enq && v != 2'b00) begin
        for (int s = 0; s < IN_W; s++) begin
          if (v[s]) begin
            m = ref_decode(insts[s], pcs[s]);
            if (m.nop) begin
              if (m_drop < 65535) m_drop++;
            end else begin
              m_q.push_back(m);
            end
          end
        end
      end
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, ordy);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) idle(1'b1);
  endtask

  initial begin
    logic [1:0] v;
    logic       ordy;
    logic       fl;
    logic       r;
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    idle(1'b0);
    check_eq("reset_in_ready", 64'(in_ready), 64'd1);
    check_eq("reset_occ", 64'(occupancy), 64'd0);

    // addu followed by lw
    step(1'b0, 1'b0, 2'b11, 32'h012A4021, 32'h8FA80004, 1'b0);
    idle(1'b0);
    check_eq("addu_rr1", 64'(out_rr1), 64'd9);
    check_eq("addu_rr2", 64'(out_rr2), 64'd10);
    check_eq("addu_rw", 64'(out_rw), 64'd8);
    check_eq("addu_flags", 64'(out_flags), 64'h04);
    check_eq("addu_cb", 64'(out_could_branch), 64'd0);
    idle(1'b1);
    idle(1'b0);
    check_eq("lw_rr1", 64'(out_rr1), 64'd29);
    check_eq("lw_rr2", 64'(out_rr2), 64'd0);
    check_eq("lw_rw", 64'(out_rw), 64'd8);
    check_eq("lw_flags", 64'(out_flags), 64'h01);
    check_eq("lw_cb", 64'(out_could_branch), 64'd1);
    drain(2);

    // nop dropped, jal kept
    step(1'b0, 1'b0, 2'b11, 32'h00000000, 32'h0C000010, 1'b0);
    idle(1'b0);
    check_eq("jal_occ", 64'(occupancy), 64'd1);
    check_eq("jal_dropped", 64'(nop_dropped), 64'd1);
    check_eq("jal_rw", 64'(out_rw), 64'd31);
    check_eq("jal_rr1", 64'(out_rr1), 64'd0);
    check_eq("jal_rr2", 64'(out_rr2), 64'd0);
    check_eq("jal_branch", 64'(out_flags[5]), 64'd1);
    drain(2);

    // trapping add is never a nop, even with rd=0
    step(1'b0, 1'b0, 2'b11, 32'h012A4020, 32'h012A0020, 1'b0);
    idle(1'b0);
    check_eq("add_occ", 64'(occupancy), 64'd2);
    check_eq("add_cb", 64'(out_could_branch), 64'd1);
    check_eq("add_nop", 64'(out_nop), 64'd0);
    drain(3);

    // fill to full, overflow attempt ignored, drain until in_ready returns
    for (int k = 0; k < 4; k++)
      step(1'b0, 1'b0, 2'b11, 32'h01200021 | (32'(2*k+1) << 11), 32'h01200021 | (32'(2*k+2) << 11), 1'b0);
    idle(1'b0);
    check_eq("full_occ", 64'(occupancy), 64'd8);
    check_eq("full_in_ready", 64'(in_ready), 64'd0);
    step(1'b0, 1'b0, 2'b11, 32'h01207821, 32'h01207821, 1'b0);
    idle(1'b1);
    check_eq("full_ignored_occ", 64'(occupancy), 64'd8);
    idle(1'b1);
    check_eq("occ7_in_ready", 64'(in_ready), 64'd0);
    idle(1'b0);
    check_eq("occ6_in_ready", 64'(in_ready), 64'd1);
    idle(1'b1);
    idle(1'b0);
    check_eq("pre_flush_occ", 64'(occupancy), 64'd5);

    // flush with a same-cycle enqueue and dequeue
    step(1'b0, 1'b1, 2'b11, 32'h01204021, 32'h01204821, 1'b1);
    idle(1'b0);
    check_eq("flush_occ", 64'(occupancy), 64'd0);
    check_eq("flush_valid", 64'(out_valid), 64'd0);

    // reset mid-stream
    step(1'b0, 1'b0, 2'b11, 32'h00000000, 32'h01204021, 1'b0);
    step(1'b1, 1'b0, 2'b11, 32'h01204021, 32'h01204821, 1'b0);
    idle(1'b0);
    check_eq("rst_occ", 64'(occupancy), 64'd0);
    check_eq("rst_dropped", 64'(nop_dropped), 64'd0);

    // randomized traffic, exercising full, wrap, flush and reset
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 2))
        0: v = 2'b00;
        1: v = 2'b01;
        default: v = 2'b11;
      endcase
      ordy = (c < 1500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 399) == 0);
      step(r, fl, v, gen_inst(), gen_inst(), ordy);
    end
    drain(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
